// File: rtl/alu_muldiv_pkg.sv
// Shared CPU definitions: ALU opcodes, multiply/divide op encodings and
// the multiply/divide engine state type.
package alu_muldiv_pkg;

    // ALU operation codes driven by the ALU decoder
    typedef enum logic [4:0] {
        ALU_AND = 5'b00000,
        ALU_OR  = 5'b00001,
        ALU_ADD = 5'b00010,
        ALU_SUB = 5'b00110,
        ALU_SLT = 5'b00111,
        ALU_NOR = 5'b01100,
        ALU_XOR = 5'b01101,
        ALU_SLL = 5'b10000,
        ALU_SRL = 5'b11000,
        ALU_SRA = 5'b11001
    } alu_op_e;

    // Multiply/divide operation encodings (bit 1 selects divide)
    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    // Engine states
    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_FIX  = 2'd2
    } md_state_e;

    // Index of the last iteration step (32 steps, count 0..31)
    localparam logic [4:0] MD_LAST_STEP = 5'd31;

    // Magnitude of a value, treating it as signed only when asked to
    function automatic logic [31:0] md_mag(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/alu_muldiv_md_engine.sv
// Iterative 32-step multiply/divide engine holding HI/LO.
// Multiply: shift-add on a {upper, multiplier} register.
// Divide: restoring division on a {remainder, quotient} register.
// Handshake: md_start is sampled on a rising edge only while the engine
// is IDLE; busy stays high through the done cycle, and a start presented
// in the done cycle is accepted because the engine is already IDLE then.
module md_engine
    import alu_muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output md_state_e   state_o
);

    md_state_e   state_q;
    logic [4:0]  count_q;
    logic [63:0] acc_q;     // mult: {partial, multiplier}; div: {remainder, quotient}
    logic [31:0] opnd_q;    // multiplicand or divisor magnitude
    logic        is_div_q;
    logic        neg_res_q; // negate product / quotient
    logic        neg_rem_q; // negate remainder (dividend was negative)
    logic        div_zero_q;
    logic [31:0] hi_q, lo_q;
    logic        busy_q, done_q;

    // Operand decode at acceptance
    logic        op_signed, op_div, a_neg, b_neg;
    logic [31:0] a_mag, b_mag;

    // Iteration step and final sign correction
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_trial;
    logic        div_ge;
    logic [31:0] div_diff;
    logic [63:0] div_next;
    logic [63:0] prod_fix;
    logic [31:0] fix_hi, fix_lo;

    // Decode the requested operation and operand magnitudes
    always_comb begin
        op_signed = (op_i == MD_MULT) || (op_i == MD_DIV);
        op_div    = op_i[1];
        a_neg     = op_signed & a_i[31];
        b_neg     = op_signed & b_i[31];
        a_mag     = md_mag(a_i, op_signed);
        b_mag     = md_mag(b_i, op_signed);
    end

    // One multiply step and one divide step from the current accumulator
    always_comb begin
        mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
        mul_next  = {mul_sum, acc_q[31:1]};
        div_trial = {acc_q[63:32], acc_q[31]};
        div_ge    = div_trial >= {1'b0, opnd_q};
        // When div_ge holds the difference is below the divisor, so 32 bits suffice
        div_diff  = div_trial[31:0] - opnd_q;
        div_next  = {(div_ge ? div_diff : div_trial[31:0]), acc_q[30:0], div_ge};
    end

    // Sign correction of the finished result
    always_comb begin
        prod_fix = neg_res_q ? (64'd0 - acc_q) : acc_q;
        if (is_div_q) begin
            fix_lo = div_zero_q ? 32'hFFFF_FFFF
                                : (neg_res_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0]);
            fix_hi = neg_rem_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
        end else begin
            fix_lo = prod_fix[31:0];
            fix_hi = prod_fix[63:32];
        end
    end

    // Engine FSM with its datapath registers and registered status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= MD_IDLE;
            count_q    <= 5'd0;
            acc_q      <= 64'd0;
            opnd_q     <= 32'd0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                MD_IDLE: begin
                    if (start_i) begin
                        acc_q      <= {32'd0, (op_div ? a_mag : b_mag)};
                        opnd_q     <= op_div ? b_mag : a_mag;
                        is_div_q   <= op_div;
                        neg_res_q  <= a_neg ^ b_neg;
                        neg_rem_q  <= a_neg;
                        div_zero_q <= (b_i == 32'd0);
                        count_q    <= 5'd0;
                        busy_q     <= 1'b1;
                        state_q    <= MD_RUN;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                MD_RUN: begin
                    acc_q   <= is_div_q ? div_next : mul_next;
                    count_q <= count_q + 5'd1;
                    if (count_q == MD_LAST_STEP) begin
                        state_q <= MD_FIX;
                    end
                end
                MD_FIX: begin
                    hi_q    <= fix_hi;
                    lo_q    <= fix_lo;
                    done_q  <= 1'b1;
                    count_q <= 5'd0;
                    state_q <= MD_IDLE;
                end
                default: begin
                    state_q <= MD_IDLE;
                end
            endcase
        end
    end

    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign hi_o    = hi_q;
    assign lo_o    = lo_q;
    assign state_o = state_q;

endmodule

// File: rtl/alu_muldiv.sv
// Combinational ALU plus the iterative multiply/divide engine with HI/LO.
module alu_muldiv
    import alu_muldiv_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        ALUCtl,
    input  logic              Sign,
    input  logic [DATA_W-1:0] in1,
    input  logic [DATA_W-1:0] in2,
    output logic [DATA_W-1:0] Out,
    output logic              Zero,
    input  logic              md_start,
    input  logic [1:0]        md_op,
    output logic              md_busy,
    output logic              md_done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output md_state_e         md_state_o
);

    logic [4:0] shamt;
    logic       lt;

    assign shamt = in1[4:0];

    // Signed or unsigned less-than for SLT
    always_comb begin
        lt = Sign ? ($signed(in1) < $signed(in2)) : (in1 < in2);
    end

    // ALU result selection; unknown codes produce zero
    always_comb begin
        Out = '0;
        case (ALUCtl)
            ALU_AND: Out = in1 & in2;
            ALU_OR:  Out = in1 | in2;
            ALU_ADD: Out = in1 + in2;
            ALU_SUB: Out = in1 - in2;
            ALU_SLT: Out = {{(DATA_W-1){1'b0}}, lt};
            ALU_NOR: Out = ~(in1 | in2);
            ALU_XOR: Out = in1 ^ in2;
            ALU_SLL: Out = in2 << shamt;
            ALU_SRL: Out = in2 >> shamt;
            ALU_SRA: Out = $signed(in2) >>> shamt;
            default: Out = '0;
        endcase
    end

    assign Zero = (Out == '0);

    md_engine u_md_engine (
        .clk     (clk),
        .reset   (reset),
        .start_i (md_start),
        .op_i    (md_op),
        .a_i     (in1),
        .b_i     (in2),
        .busy_o  (md_busy),
        .done_o  (md_done),
        .hi_o    (hi),
        .lo_o    (lo),
        .state_o (md_state_o)
    );

endmodule

// File: tb/tb_alu_muldiv.sv
module tb_alu_muldiv;

  logic        clk;
  logic        reset;
  logic [4:0]  ALUCtl;
  logic        Sign;
  logic [31:0] in1, in2;
  logic [31:0] Out;
  logic        Zero;
  logic        md_start;
  logic [1:0]  md_op;
  logic        md_busy, md_done;
  logic [31:0] hi, lo;
  logic [1:0]  md_state;

  int n_cmp = 0;
  int n_err = 0;

  alu_muldiv dut (
    .clk        (clk),
    .reset      (reset),
    .ALUCtl     (ALUCtl),
    .Sign       (Sign),
    .in1        (in1),
    .in2        (in2),
    .Out        (Out),
    .Zero       (Zero),
    .md_start   (md_start),
    .md_op      (md_op),
    .md_busy    (md_busy),
    .md_done    (md_done),
    .hi         (hi),
    .lo         (lo),
    .md_state_o (md_state)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [4:0]  ctl;
    logic        sign;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_out;
    logic        exp_zero;
  } alu_vec_t;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } md_vec_t;

  alu_vec_t alu_tab[15];
  md_vec_t  md_tab[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver: present a start for one cycle (caller is #1 after an edge)
  task automatic do_start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    md_op    = op;
    in1      = a;
    in2      = b;
    md_start = 1'b1;
    @(posedge clk);
    #1;
    md_start = 1'b0;
  endtask

  // wait for md_done, counting edges since acceptance; bounded
  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!md_done && lat < 60);
  endtask

  // full multiply/divide transaction with result and timing checks
  task automatic run_md(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    int lat;
    do_start(op, a, b);
    check({name, " busy after accept"}, 64'(md_busy), 64'd1);
    wait_done(lat);
    check({name, " latency"}, 64'(lat), 64'd33);
    check({name, " hi"}, 64'(hi), 64'(ehi));
    check({name, " lo"}, 64'(lo), 64'(elo));
    check({name, " busy in done cycle"}, 64'(md_busy), 64'd1);
    @(posedge clk);
    #1;
    check({name, " done pulse ends"}, 64'(md_done), 64'd0);
    check({name, " busy ends"}, 64'(md_busy), 64'd0);
    check({name, " hi held"}, 64'(hi), 64'(ehi));
    check({name, " lo held"}, 64'(lo), 64'(elo));
  endtask

  initial begin
    int lat;
    int ndone;
    logic [31:0] cap_hi, cap_lo;

    alu_tab[0]  = '{5'b00010, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0};
    alu_tab[1]  = '{5'b00110, 1'b0, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1};
    alu_tab[2]  = '{5'b00111, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0};
    alu_tab[3]  = '{5'b00111, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1};
    alu_tab[4]  = '{5'b11001, 1'b0, 32'h0000_001F, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0};
    alu_tab[5]  = '{5'b11000, 1'b0, 32'h0000_001F, 32'h8000_0000, 32'h0000_0001, 1'b0};
    alu_tab[6]  = '{5'b10000, 1'b0, 32'h0000_0004, 32'h0000_000F, 32'h0000_00F0, 1'b0};
    alu_tab[7]  = '{5'b00000, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0};
    alu_tab[8]  = '{5'b00001, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0};
    alu_tab[9]  = '{5'b01101, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0};
    alu_tab[10] = '{5'b01100, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h000F_000F, 1'b0};
    alu_tab[11] = '{5'b00110, 1'b0, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0};
    alu_tab[12] = '{5'b11111, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 1'b1};
    alu_tab[13] = '{5'b00010, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1};
    alu_tab[14] = '{5'b11001, 1'b0, 32'h0000_0024, 32'h8000_0000, 32'hF800_0000, 1'b0};

    md_tab[0] = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    md_tab[1] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    md_tab[2] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    md_tab[3] = '{2'b11, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF};
    md_tab[4] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    md_tab[5] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
    md_tab[6] = '{2'b11, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E};
    md_tab[7] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    md_tab[8] = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};

    // reset block
    reset    = 1'b1;
    md_start = 1'b0;
    md_op    = 2'b00;
    ALUCtl   = 5'b00010;
    Sign     = 1'b0;
    in1      = 32'd2;
    in2      = 32'd3;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 64'(md_busy), 64'd0);
    check("reset done", 64'(md_done), 64'd0);
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    check("reset state", 64'(md_state), 64'd0);
    check("alu during reset", 64'(Out), 64'd5);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // ALU vector table
    for (int i = 0; i < 15; i++) begin
      ALUCtl = alu_tab[i].ctl;
      Sign   = alu_tab[i].sign;
      in1    = alu_tab[i].a;
      in2    = alu_tab[i].b;
      #1;
      check($sformatf("alu[%0d] Out", i), 64'(Out), 64'(alu_tab[i].exp_out));
      check($sformatf("alu[%0d] Zero", i), 64'(Zero), 64'(alu_tab[i].exp_zero));
    end

    // multiply/divide vector table
    @(posedge clk);
    #1;
    for (int i = 0; i < 9; i++) begin
      run_md($sformatf("md[%0d]", i), md_tab[i].op, md_tab[i].a, md_tab[i].b,
             md_tab[i].exp_hi, md_tab[i].exp_lo);
    end

    // start held high while busy with changing operands: one result only
    do_start(2'b01, 32'h0000_1234, 32'h0000_0010);
    md_start = 1'b1;
    ndone = 0;
    cap_hi = 32'd0;
    cap_lo = 32'd0;
    for (int i = 1; i <= 80; i++) begin
      @(posedge clk);
      #1;
      if (md_done) begin
        ndone++;
        cap_hi = hi;
        cap_lo = lo;
      end
      if (i < 32) begin
        in1 = $urandom;
        in2 = $urandom_range(1, 32'h7FFF_FFFF);
      end else if (i == 32) begin
        md_start = 1'b0;
      end
    end
    check("held start done count", 64'(ndone), 64'd1);
    check("held start hi", 64'(cap_hi), 64'd0);
    check("held start lo", 64'(cap_lo), 64'h0001_2340);

    // back-to-back: start presented in the done cycle
    @(posedge clk);
    #1;
    do_start(2'b00, 32'h0000_0006, 32'hFFFF_FFF9);
    wait_done(lat);
    check("b2b first latency", 64'(lat), 64'd33);
    check("b2b first hi", 64'(hi), 64'hFFFF_FFFF);
    check("b2b first lo", 64'(lo), 64'hFFFF_FFD6);
    do_start(2'b11, 32'h0000_03E8, 32'h0000_0003);
    check("b2b second accepted", 64'(md_busy), 64'd1);
    wait_done(lat);
    check("b2b second latency", 64'(lat), 64'd33);
    check("b2b second hi", 64'(hi), 64'd1);
    check("b2b second lo", 64'(lo), 64'd333);
    @(posedge clk);
    #1;

    // reset in the middle of RUN
    do_start(2'b01, 32'd5, 32'd6);
    repeat (10) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("mid-run reset busy", 64'(md_busy), 64'd0);
    check("mid-run reset done", 64'(md_done), 64'd0);
    check("mid-run reset hi", 64'(hi), 64'd0);
    check("mid-run reset lo", 64'(lo), 64'd0);
    check("mid-run reset state", 64'(md_state), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 45; i++) begin
      @(posedge clk);
      #1;
      if (md_done) ndone++;
    end
    check("aborted op done count", 64'(ndone), 64'd0);
    check("aborted op hi", 64'(hi), 64'd0);
    check("aborted op lo", 64'(lo), 64'd0);
    run_md("after reset", 2'b01, 32'd5, 32'd6, 32'd0, 32'd30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
